// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, plus the
// per-register busy scoreboard that the issue stage uses for hazard checks.
module regfile_wb_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [5*NREQ-1:0]     req_reg,
   input  logic [WIDTH*NREQ-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  issue_valid,
   input  logic [4:0]            issue_reg,
   output logic                  RegWrite,
   output logic [4:0]            w_reg,
   output logic [WIDTH-1:0]      write_data,
   output logic [31:0]           busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_found;
   logic [4:0]       grant_reg;
   logic [WIDTH-1:0] grant_data;
   logic [31:0]      busy_next;
   int               cand;

   // Search from ptr upward, wrapping, and take the first valid requester.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      grant_reg  = '0;
      grant_data = '0;
      req_ready  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == PTR_W'(i)) begin
            grant_reg  = req_reg[5*i +: 5];
            grant_data = req_data[WIDTH*i +: WIDTH];
         end
         req_ready[i] = rst_n & grant_found & (grant_idx == PTR_W'(i));
      end
   end

   always_comb begin
      if (grant_idx == PTR_W'(NREQ-1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant_idx + PTR_W'(1);
      end
   end

   // Clear first, then set: a same-edge issue means a newer producer is in flight.
   always_comb begin
      busy_next = busy;
      if (grant_found && grant_reg != 5'd0) begin
         busy_next[grant_reg] = 1'b0;
      end
      if (issue_valid && issue_reg != 5'd0) begin
         busy_next[issue_reg] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         RegWrite   <= 1'b0;
         w_reg      <= '0;
         write_data <= '0;
         busy       <= '0;
      end else begin
         busy <= busy_next;
         if (grant_found) begin
            ptr        <= ptr_next;
            RegWrite   <= (grant_reg != 5'd0);
            w_reg      <= grant_reg;
            write_data <= grant_data;
         end else begin
            RegWrite <= 1'b0;
         end
      end
   end

endmodule
